// File: rtl/instruction_sequencer.sv
// Buffers host instructions and issues them to control_circuit for exactly their execution length.
// Latency: push to INSTRUCTION valid is 2 cycles. Each instruction takes 1 + length cycles.
// Backpressure: in_ready drops when the FIFO is full. `define SEQ_STEP_EN adds a step-gated launch.

module seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdat    = mem[rd_ptr];
    assign count   = cnt;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdat;
    end
endmodule

module instruction_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [10:0]              in_instr,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     run,
`ifdef SEQ_STEP_EN
    input  logic                     step,
`endif
    output logic [10:0]              INSTRUCTION,
    output logic [DATA_W-1:0]        ext_data,
    output logic                     busy,
    output logic                     retire,
    output logic                     cmd_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam logic [10:0] NOP = {3'b111, 8'h00};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [10:0]             cur_instr;
    logic [DATA_W-1:0]       cur_data;
    logic [1:0]              cnt;
    logic                    pop;
    logic                    launch_ok;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic [DATA_W+10:0]      fifo_head;

    // Remaining EXEC cycles after the first one, derived from the opcode alone.
    function automatic logic [1:0] exec_cnt_init(input logic [2:0] op);
        case (op[1:0])
            2'b00:   exec_cnt_init = 2'd1;
            2'b01:   exec_cnt_init = 2'd0;
            default: exec_cnt_init = 2'd2;
        endcase
    endfunction

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready && !in_instr[10];

    seq_fifo #(
        .WIDTH (DATA_W + 11),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdat  ({in_data, in_instr}),
        .pop   (pop),
        .rdat  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef SEQ_STEP_EN
    logic step_pend;

    // A pulse coinciding with a launch is kept for the next launch point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) step_pend <= 1'b0;
        else       step_pend <= pop ? step : (step_pend | step);
    end

    assign launch_ok = !fifo_empty && run && step_pend;
`else
    assign launch_ok = !fifo_empty && run;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (launch_ok) begin
                    state_nxt = S_ISSUE;
                    pop       = 1'b1;
                end
            end
            S_ISSUE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (cnt == 2'd0) begin
                    if (launch_ok) begin
                        state_nxt = S_ISSUE;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_instr <= NOP;
            cur_data  <= '0;
            cnt       <= 2'd0;
            cmd_err   <= 1'b0;
        end else begin
            if (pop) {cur_data, cur_instr} <= fifo_head;
            if (state == S_ISSUE)
                cnt <= exec_cnt_init(cur_instr[10:8]);
            else if (state == S_EXEC && cnt != 2'd0)
                cnt <= cnt - 2'd1;
            cmd_err <= in_valid && in_ready && in_instr[10];
        end
    end

    // control_circuit decodes operands combinationally, so hold them through every EXEC cycle.
    assign busy        = (state != S_IDLE);
    assign INSTRUCTION = busy ? cur_instr : NOP;
    assign ext_data    = busy ? cur_data : '0;
    assign retire      = (state == S_EXEC) && (cnt == 2'd0);
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed and randomized bench for instruction_sequencer against a queue-based reference model.
`timescale 1ns/1ps
module tb_instruction_sequencer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam logic [10:0] NOP = 11'h700;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [10:0]       in_instr;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              run;
`ifdef SEQ_STEP_EN
    logic              step;
`endif
    logic [10:0]       INSTRUCTION;
    logic [DATA_W-1:0] ext_data;
    logic              busy;
    logic              retire;
    logic              cmd_err;
    logic [2:0]        fifo_count;

    int checks = 0;
    int errors = 0;

    instruction_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .run         (run),
`ifdef SEQ_STEP_EN
        .step        (step),
`endif
        .INSTRUCTION (INSTRUCTION),
        .ext_data    (ext_data),
        .busy        (busy),
        .retire      (retire),
        .cmd_err     (cmd_err),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: pending queue plus the instruction currently occupying the bus.
    logic [10:0]       mq_i[$];
    logic [DATA_W-1:0] mq_d[$];
    bit                m_act;
    int                m_rem;
    logic [10:0]       m_i;
    logic [DATA_W-1:0] m_d;
    bit                m_err;
    bit                m_step;

    function automatic int exec_len(input logic [2:0] op);
        case (op)
            3'd0:    return 2;
            3'd1:    return 1;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        mq_i.delete();
        mq_d.delete();
        m_act  = 0;
        m_rem  = 0;
        m_i    = NOP;
        m_d    = '0;
        m_err  = 0;
        m_step = 0;
    endtask

    task automatic model_edge();
        int sz;
        bit can;
        sz  = mq_i.size();
        can = (!m_act || m_rem == 1) && sz > 0 && run;
`ifdef SEQ_STEP_EN
        can = can && m_step;
`endif
        if (m_act) begin
            m_rem--;
            if (m_rem == 0) m_act = 0;
        end
        if (can) begin
            m_i   = mq_i.pop_front();
            m_d   = mq_d.pop_front();
            m_act = 1;
            m_rem = 1 + exec_len(m_i[10:8]);
        end
`ifdef SEQ_STEP_EN
        m_step = can ? step : (m_step || step);
`endif
        m_err = 0;
        if (in_valid && sz < DEPTH) begin
            if (in_instr[10]) m_err = 1;
            else begin
                mq_i.push_back(in_instr);
                mq_d.push_back(in_data);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("instr",   32'(INSTRUCTION), m_act ? 32'(m_i) : 32'(NOP));
        chk("ext",     32'(ext_data),    m_act ? 32'(m_d) : 32'h0);
        chk("busy",    32'(busy),        32'(m_act));
        chk("retire",  32'(retire),      32'(m_act && m_rem == 1));
        chk("cmd_err", 32'(cmd_err),     32'(m_err));
        chk("count",   32'(fifo_count),  32'(mq_i.size()));
        chk("ready",   32'(in_ready),    32'(mq_i.size() < DEPTH));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Called at a negedge; asserts reset between edges and checks the asynchronous response.
    task automatic do_reset();
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_instr",  32'(INSTRUCTION), 32'(NOP));
        chk("rst_retire", 32'(retire),      32'h0);
        chk("rst_count",  32'(fifo_count),  32'h0);
        chk("rst_ready",  32'(in_ready),    32'h1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        int rcnt;
        int t_add;
        int t_sub;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        in_data  = '0;
        run      = 1'b0;
`ifdef SEQ_STEP_EN
        step     = 1'b1;
`endif
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single load: held cycles 2..4 after the push, retire on 4.
        run      = 1'b1;
        in_valid = 1'b1;
        in_instr = 11'h010;
        in_data  = 8'h5A;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            in_valid = 1'b0;
            chk("t1_instr",  32'(INSTRUCTION), (k >= 2 && k <= 4) ? 32'h010 : 32'(NOP));
            chk("t1_data",   32'(ext_data),    (k >= 2 && k <= 4) ? 32'h5A : 32'h0);
            chk("t1_retire", 32'(retire),      32'(k == 4));
        end

        // add then sub back-to-back: 4 cycles each, no bubble.
        in_valid = 1'b1;
        in_instr = 11'h212;
        in_data  = 8'h00;
        t_add = -1;
        t_sub = -1;
        for (int k = 1; k <= 11; k++) begin
            cycle();
            if (k == 1) in_instr = 11'h334;
            else        in_valid = 1'b0;
            if (INSTRUCTION == 11'h212 && t_add < 0) t_add = k;
            if (INSTRUCTION == 11'h334 && t_sub < 0) t_sub = k;
            chk("t2_instr",  32'(INSTRUCTION),
                (k >= 2 && k <= 5) ? 32'h212 : (k >= 6 && k <= 9) ? 32'h334 : 32'(NOP));
            chk("t2_retire", 32'(retire), 32'(k == 5 || k == 9));
        end
        chk("t2_spacing", 32'(t_sub - t_add), 32'd4);

        // Fill with run low; the fifth push must be refused.
        run      = 1'b0;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_instr = 11'h100 | 11'(k);
            cycle();
        end
        in_valid = 1'b0;
        chk("t3_full_count", 32'(fifo_count), 32'd4);
        chk("t3_full_ready", 32'(in_ready),   32'd0);
        run  = 1'b1;
        rcnt = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (retire) rcnt++;
            chk("t3_retire", 32'(retire), 32'(k % 2 == 0 && k <= 8));
        end
        chk("t3_retires", 32'(rcnt),       32'd4);
        chk("t3_drained", 32'(fifo_count), 32'd0);

        // Invalid opcode is dropped with a one-cycle error pulse.
        in_valid = 1'b1;
        in_instr = 11'h5A3;
        cycle();
        in_valid = 1'b0;
        chk("t4_err",   32'(cmd_err),     32'd1);
        chk("t4_count", 32'(fifo_count),  32'd0);
        chk("t4_instr", 32'(INSTRUCTION), 32'(NOP));
        cycle();
        chk("t4_err_clr", 32'(cmd_err), 32'd0);

        // Reset in the second EXEC cycle of an add with two instructions queued.
        run      = 1'b0;
        in_valid = 1'b1;
        in_instr = 11'h212; cycle();
        in_instr = 11'h1AB; cycle();
        in_instr = 11'h1CD; cycle();
        in_valid = 1'b0;
        run      = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("t5_busy",  32'(busy),       32'd1);
        chk("t5_queue", 32'(fifo_count), 32'd2);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t5_no_retire", 32'(retire), 32'd0);
        end

`ifdef SEQ_STEP_EN
        // One step pulse launches exactly one of three queued movs.
        step     = 1'b0;
        run      = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_instr = 11'h111 + 11'(k);
            cycle();
        end
        in_valid = 1'b0;
        step = 1'b1;
        cycle();
        step = 1'b0;
        rcnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (retire) rcnt++;
        end
        chk("t6_one_issue", 32'(rcnt),       32'd1);
        chk("t6_left",      32'(fifo_count), 32'd2);
        step = 1'b1;
        cycle();
        step = 1'b0;
        rcnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (retire) rcnt++;
        end
        chk("t6_second", 32'(rcnt), 32'd1);
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 800; n++) begin
            logic [2:0] op;
            op       = ($urandom_range(0, 9) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 1) == 1);
            in_instr = {op, 8'($urandom)};
            in_data  = 8'($urandom);
            run      = ($urandom_range(0, 9) < 7);
`ifdef SEQ_STEP_EN
            step     = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Buffers host-supplied instructions, each with an optional load datum, in a small FIFO.
- Issues them one at a time to control_circuit's 11-bit INSTRUCTION input. Each instruction is held for exactly as many cycles as control_circuit takes to execute it.
- Tracks execution length internally from the opcode, so it needs no feedback from control_circuit.
- Sits between the host/testbench and control_circuit. Shares clk and reset with control_circuit so both leave reset aligned.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- DATA_W, 8, width of the load datum sent to the external bus.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  host offers an instruction.
- in_instr  input  11  {opcode[10:8], Rx[7:4], Ry[3:0]}.
- in_data  input  DATA_W  datum for load instructions; ignored for other opcodes.
- in_ready  output  1  FIFO not full.
- run  input  1  launch enable; never stalls an instruction already in flight.
- INSTRUCTION  output  11  drives control_circuit.
- ext_data  output  DATA_W  external load bus value.
- busy  output  1  ISSUE or EXEC state.
- retire  output  1  one-cycle pulse on the final execution cycle.
- cmd_err  output  1  one-cycle pulse when an invalid opcode is dropped.
- fifo_count  output  $clog2(DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Opcodes and execution length (cycles after the issue cycle): load 000 = 2, mov 001 = 1, add 010 = 3, sub 011 = 3.
- NOP is {3'b111, 8'h00}. control_circuit stays in initial_state while it sees NOP.
- Reset (asynchronous, any time, including mid-instruction):
  - state IDLE; FIFO emptied; INSTRUCTION = NOP; ext_data = 0.
  - busy, retire, cmd_err = 0; fifo_count = 0; in_ready = 1.
  - Any in-flight instruction is abandoned and never retires.
- Push: accepted when in_valid && in_ready.
  - An opcode of 1xx is not stored; cmd_err pulses in the next cycle.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - When full, in_ready = 0 and the FIFO offers no same-cycle pass-through.
- Pointers wrap modulo DEPTH.
- States:
  - IDLE: INSTRUCTION = NOP, ext_data = 0. If the FIFO is non-empty and run = 1: load the head into cur_instr/cur_data, pop, go to ISSUE.
  - ISSUE (1 cycle): INSTRUCTION = cur_instr; control_circuit samples it in initial_state. Load cnt = length - 1. Go to EXEC.
  - EXEC: INSTRUCTION and ext_data hold cur values, because control_circuit decodes the operand combinationally in every state. Decrement cnt each cycle. When cnt = 0, pulse retire. Then:
    - if the FIFO is non-empty and run = 1: load the next head, pop, go to ISSUE (back-to-back);
    - otherwise go to IDLE.
- Throughput is 1 + length cycles per instruction with no bubbles. Latency from push acceptance (idle sequencer) to INSTRUCTION valid is 2 cycles.
- ext_data is held from ISSUE through the last EXEC cycle, so it is stable when control_circuit asserts External_load in Load2.
- run deasserting mid-instruction has no effect until the final EXEC cycle.

Optional Feature:
- SEQ_STEP_EN defined:
  - adds input step (1 bit);
  - a launch from IDLE or from the final EXEC cycle additionally requires a step pulse;
  - step is registered, so one pulse launches at most one instruction;
  - a pulse arriving while busy is held pending until the next launch point.
- Undefined: no step port; launches depend only on run and FIFO occupancy.

Test Plan:
- Reset then push {000,0001,0000}, data 8'h5A, run = 1 -> INSTRUCTION = 11'h010 at cycles 2–4 after push; ext_data = 8'h5A over the same cycles; retire at cycle 4; NOP at cycle 5.
- Push add R1,R2 then sub R3,R4 back-to-back -> issue cycles 4 apart (add 11'h212 for 4 cycles, then sub 11'h334 for 4 cycles); two retire pulses 4 cycles apart.
- run = 0, push DEPTH = 4 movs -> fifo_count = 4, in_ready = 0; a 5th push is ignored. Then run = 1 -> four issues 2 cycles apart; fifo_count falls to 0.
- Push opcode 3'b101 -> cmd_err pulses; fifo_count stays 0; INSTRUCTION stays NOP.
- Assert reset during the 2nd EXEC cycle of an add with 2 instructions queued -> every output takes its reset value immediately; no retire; fifo_count = 0.
- With SEQ_STEP_EN, 3 queued movs and one step pulse -> exactly one issue; the second issues only after the next step pulse.
